ram2x8_arbiter: RTL
===================

// Module: ram2x8_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer sharing one 2-word x 8-bit RAM (ram2x8) between two requesters.
//  Each requester posts a one-word read or write over a req/ack handshake.
//  The block drives the RAM's readWrite, address and data pins, then registers the read data.
//  Sits between the RAM and its two clients on a single clock.
// PARAMETERS
//  DW     8   data width of a RAM word
//  NREQ   2   number of requesters (fixed; the port list assumes 2)
// PORTS
//  clk        in   1   system clock, rising edge active
//  clear      in   1   reset, asynchronous, active-low (0 = reset)
//  req        in   2   request per requester; held high until the matching ack bit
//  we         in   2   per requester: 1 = write, 0 = read; stable while req is high
//  addr       in   2   per requester word address (bit i = requester i)
//  wdata0     in   DW  requester 0 write data
//  wdata1     in   DW  requester 1 write data
//  gnt        out  2   one-hot grant; high for the whole transaction
//  ack        out  2   one-cycle completion pulse per requester
//  rdata      out  DW  registered read data; valid in the ack cycle and held until the next read
//  busy       out  1   high when state != IDLE
//  ram_rw     out  1   to RAM readWrite (1 = write)
//  ram_addr   out  1   to RAM address
//  ram_din    out  DW  to RAM data in
//  ram_dout   in   DW  from RAM data out
// BEHAVIOUR
//  Reset (clear=0, async): state=IDLE, gnt=00, ack=00, rdata=0, ram_rw=0, ram_addr=0, ram_din=0, last=1.
//   last=1 makes requester 0 win the first tie.
//  FSM IDLE -> ACCESS -> DONE -> IDLE, 3 cycles per transaction, no pipelining.
//  IDLE: on an edge with req!=00, pick the winner.
//   Single request: that requester. Both: requester != last. Load gnt, ram_addr, ram_din, ram_rw=we[w].
//  ACCESS: RAM pins held; the RAM writes on this edge if ram_rw=1; ram_dout sampled into rdata if read.
//  DONE: ram_rw=0, ack[w]=1 for exactly one cycle, last<=w, gnt cleared on exit.
//  Latency: req seen at edge N -> ack high during cycle N+2; next grant earliest edge N+3.
//  A write leaves rdata unchanged.
//  req dropped mid-transaction: the transaction still completes and ack still pulses; no abort.
//  Requester re-asserting req right after its ack: if the other requester is waiting, the waiter wins.
//  Requests arriving while busy wait; none are lost while req is held.
//  Reset mid-transaction: everything returns to reset values at once; a pending RAM write is dropped
//   because ram_rw is forced to 0.
//  ram_rw is 1 only in ACCESS; never high in IDLE or DONE.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: requester 0 always wins ties; last is not used.
//  Not defined (default): round-robin as above.
// STRUCTURE
//  Shared header ram_arb_defs.vh: state codes ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2;
//   RW_READ=1'b0, RW_WRITE=1'b1.
//  Sub-module rr_pick2: combinational (req[1:0], last) -> winner index + valid.
//   Holds the ARB_FIXED_PRIO_EN switch.
//  Top holds the FSM, registers and RAM pin drive.
//  ram2x8 is instanced by the testbench, not inside this block.
// TESTING (bench instances ram2x8 + ram2x8_arbiter + clock)
//  Reset with clear=0 -> gnt=00, ack=00, rdata=00, busy=0, ram_rw=0.
//  Req0 write addr0 wdata0=8'hDA; then req1 read addr0
//   -> ack0 at cycle 2, then rdata=8'hDA with ack1.
//  req=11 both held from reset -> grants 01,10,01,10 alternate.
//   With ARB_FIXED_PRIO_EN: 01,01,01.
//  Req1 write addr1 8'h3C, drop req after 1 cycle
//   -> ack1 still pulses; req0 read addr1 returns 8'h3C.
//  clear=0 during ACCESS of a write 8'hFF to addr0 -> all outputs reset.
//   Read addr0 returns the prior value, not 8'hFF.
//  Back-to-back req0 reads, req1 raised mid-transaction -> req1 is granted next.
//   ram_rw never high outside ACCESS.

Source files
------------

// File: rtl/ram2x8_arbiter_pkg.sv
// Shared types and constants for the two-client ram2x8 arbiter.
package ram2x8_arbiter_pkg;

   localparam int DW   = 8;
   localparam int NREQ = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/ram2x8_arbiter_if.sv
// Client-side req/ack bus of the ram2x8 arbiter; master = requesters, slave = arbiter.
interface ram2x8_arbiter_if;
   import ram2x8_arbiter_pkg::*;

   logic [NREQ-1:0] req;
   logic [NREQ-1:0] we;
   logic [NREQ-1:0] addr;
   logic [DW-1:0]   wdata0;
   logic [DW-1:0]   wdata1;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] ack;
   logic [DW-1:0]   rdata;
   logic            busy;

   modport master (
      output req, we, addr, wdata0, wdata1,
      input  gnt, ack, rdata, busy
   );

   modport slave (
      input  req, we, addr, wdata0, wdata1,
      output gnt, ack, rdata, busy
   );

endinterface

// File: rtl/ram2x8.sv
// 2-word x 8-bit RAM: synchronous write, asynchronous read.
module ram2x8 (
   input  logic       clk,
   input  logic       readWrite,
   input  logic       address,
   input  logic [7:0] dataIn,
   output logic [7:0] dataOut
);

   logic [7:0] mem [2];

   always_ff @(posedge clk) begin
      if (readWrite) mem[address] <= dataIn;
   end

   assign dataOut = mem[address];

endmodule

// File: rtl/ram2x8_arbiter_rr_pick2.sv
// Two-way winner select. Default: round-robin on ties using last.
// Build option ARB_FIXED_PRIO_EN: requester 0 always wins ties, last ignored.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       win,
   output logic       valid
);

   assign valid = |req;

`ifdef ARB_FIXED_PRIO_EN
   assign win = ~req[0];
`else
   // On a tie the requester that did not go last wins.
   assign win = (req == 2'b11) ? ~last : req[1];
`endif

endmodule

// File: rtl/ram2x8_arbiter.sv
// Sequencer sharing one ram2x8 between two requesters, one word per 3-cycle transaction.
//  state     | meaning
//  ST_IDLE   | waiting for a request; winner chosen and RAM pins loaded on exit
//  ST_ACCESS | RAM pins held; write commits or read data captured on exit
//  ST_DONE   | ack pulse to the winner; grant released and last updated on exit
module ram2x8_arbiter
   import ram2x8_arbiter_pkg::*;
(
   input  logic            clk,
   input  logic            clear,
   ram2x8_arbiter_if.slave bus,
   output logic            ram_rw,
   output logic            ram_addr,
   output logic [DW-1:0]   ram_din,
   input  logic [DW-1:0]   ram_dout
);

   state_t          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            ram_rw_q, ram_rw_d;
   logic            ram_addr_q, ram_addr_d;
   logic [DW-1:0]   ram_din_q, ram_din_d;
   logic            last_q, last_d;
   logic            win_q, win_d;
   logic            pick_win, pick_vld;

   rr_pick2 u_pick (
      .req   (bus.req),
      .last  (last_q),
      .win   (pick_win),
      .valid (pick_vld)
   );

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         ack_q      <= '0;
         rdata_q    <= '0;
         ram_rw_q   <= RW_READ;
         ram_addr_q <= 1'b0;
         ram_din_q  <= '0;
         last_q     <= 1'b1;
         win_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
         ram_rw_q   <= ram_rw_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         last_q     <= last_d;
         win_q      <= win_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      ack_d      = '0;
      rdata_d    = rdata_q;
      ram_rw_d   = ram_rw_q;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      last_d     = last_q;
      win_d      = win_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d    = ST_ACCESS;
               win_d      = pick_win;
               gnt_d      = pick_win ? 2'b10 : 2'b01;
               ram_addr_d = bus.addr[pick_win];
               ram_din_d  = pick_win ? bus.wdata1 : bus.wdata0;
               ram_rw_d   = bus.we[pick_win] ? RW_WRITE : RW_READ;
            end
         end
         ST_ACCESS: begin
            state_d      = ST_DONE;
            if (ram_rw_q == RW_READ) rdata_d = ram_dout;
            ram_rw_d     = RW_READ;
            ack_d[win_q] = 1'b1;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            last_d  = win_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.gnt   = gnt_q;
   assign bus.ack   = ack_q;
   assign bus.rdata = rdata_q;
   assign bus.busy  = (state_q != ST_IDLE);
   assign ram_rw    = ram_rw_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;

endmodule
